vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Runtime-configurable VGA timing generator: next generation of the fixed-mode frame counter. Produces pixel/line counters, sync pulses with programmable polarity, video-active flag and frame/line strobes. An integrated clock-enable divider drives the counters. Sits between the system clock domain and the pixel pipeline / RGB output stage. Mode changes are double-buffered and applied only at a frame boundary, so no torn frame is ever emitted.

## Interface
- H_SIZE, 11, width of horizontal counter and all cfg_h_* fields
- V_SIZE, 10, width of vertical counter and all cfg_v_* fields
- CLK_DIV, 1, system clocks per pixel; 1 = tick every cycle; legal range 1..16
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, reset-time horizontal timing
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, reset-time vertical timing
- HS_POL/VS_POL, 0/0, reset-time sync polarity; 1 = active-high
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- clear  in  1  restart at pixel (0,0); applies pending config immediately
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  H_SIZE each  new horizontal timing
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  V_SIZE each  new vertical timing
- cfg_hs_pol, cfg_vs_pol  in  1 each  new sync polarities
- cfg_update  in  1  one-cycle pulse; captures all cfg_* into the pending register
- cfg_pending  out  1  pending config not yet applied
- cfg_done  out  1  one-cycle pulse; pending config became active
- pix_tick  out  1  pixel clock enable
- hcount  out  H_SIZE  current pixel column
- vcount  out  V_SIZE  current line
- hsync, vsync  out  1 each  sync outputs, polarity applied
- video_on  out  1  hcount < h_active and vcount < v_active
- line_start, frame_start, frame_end  out  1 each  single-clock strobes

## Operation
- Three register sets: active (drives counters), pending (written by cfg_update), divider/counters.
- Divider: div_cnt counts 0..CLK_DIV-1; pix_tick = (div_cnt == CLK_DIV-1). For CLK_DIV=1, pix_tick is constantly 1 outside reset.
- H_TOTAL = h_active+h_fp+h_sync+h_bp. Computed with 2 extra bits. Software guarantees it fits in H_SIZE and h_active >= 1. V_TOTAL is defined the same way.
- On pix_tick: hcount wraps from H_TOTAL-1 to 0, otherwise increments. On each h wrap, vcount wraps from V_TOTAL-1 to 0, otherwise increments. Counters hold between ticks.
- hsync is asserted (equal to hs_pol) while h_active+h_fp <= hcount < h_active+h_fp+h_sync. Otherwise it is ~hs_pol. vsync follows the same rule on vcount. A sync width of 0 means sync is never asserted.
- Strobes, all qualified by pix_tick:
  - line_start at hcount==0
  - frame_start at (0,0)
  - frame_end at (H_TOTAL-1, V_TOTAL-1)
- Config handshake:
  - cfg_update sets cfg_pending and overwrites pending. The last update before the boundary wins.
  - At a frame_end tick with cfg_pending=1: pending copies to active, cfg_pending clears, and cfg_done pulses on the next cycle.
  - If cfg_update coincides with frame_end, the values are captured but applied at the following frame_end, not this one.
- clear:
  - zeroes div_cnt, hcount, vcount
  - if cfg_pending=1, applies pending and pulses cfg_done
  - clear together with cfg_update: the new values are captured and applied at this clear
- rst, which has priority over clear:
  - active is loaded from the parameters and pending is cleared
  - cfg_pending=0, cfg_done=0, div_cnt=0, hcount=0, vcount=0
  - all strobes and pix_tick are forced 0
  - hsync = ~HS_POL, vsync = ~VS_POL

## Timing
- hcount, vcount, div_cnt, active/pending sets and cfg_done are registers. hsync, vsync, video_on and the strobes decode combinationally from the counter registers, so they have zero latency relative to hcount/vcount.
- A new config affects hsync/vsync/video_on starting at the frame_start cycle immediately after the applying frame_end.
- Changing CLK_DIV requires re-elaboration; there is no runtime divider control.
- Throughput: one pixel per CLK_DIV clocks, continuous, with no stall input.

## Test plan
- Reset defaults, CLK_DIV=1:
  - frame_end fires at hcount=799, vcount=524; next frame_start follows 420000 clocks after the first.
  - hsync low for hcount 656..751; vsync low for vcount 490..491.
  - video_on low from hcount 640 onward.
- CLK_DIV=4:
  - pix_tick pulses every 4th clock; hcount holds for 4 clocks; line_start is exactly 1 clock wide.
- Mode update mid-frame (h 8/2/4/2, v 6/1/2/1, pols 1/1):
  - cfg_pending=1 until frame_end; cfg_done pulses 1 cycle later.
  - Next frame H_TOTAL=16, V_TOTAL=10.
  - hsync high for hcount 10..13; vsync high for vcount 7..8.
- Two updates before a boundary, then update coincident with frame_end:
  - only the second value is applied at that boundary.
  - the coincident value is applied at the following boundary.
- clear at (300,200) with pending config:
  - next cycle counters are 0,0 and cfg_done=1.
  - rst asserted together with clear wins: defaults are restored and cfg_done stays 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-configurable VGA timing generator with double-buffered mode updates
module vga_timing_gen #(
  parameter int H_SIZE   = 11,
  parameter int V_SIZE   = 10,
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [H_SIZE-1:0] cfg_h_active,
  input  logic [H_SIZE-1:0] cfg_h_fp,
  input  logic [H_SIZE-1:0] cfg_h_sync,
  input  logic [H_SIZE-1:0] cfg_h_bp,
  input  logic [V_SIZE-1:0] cfg_v_active,
  input  logic [V_SIZE-1:0] cfg_v_fp,
  input  logic [V_SIZE-1:0] cfg_v_sync,
  input  logic [V_SIZE-1:0] cfg_v_bp,
  input  logic              cfg_hs_pol,
  input  logic              cfg_vs_pol,
  input  logic              cfg_update,
  output logic              cfg_pending,
  output logic              cfg_done,
  output logic              pix_tick,
  output logic [H_SIZE-1:0] hcount,
  output logic [V_SIZE-1:0] vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              line_start,
  output logic              frame_start,
  output logic              frame_end
);
  typedef struct packed {
    logic [H_SIZE-1:0] h_active;
    logic [H_SIZE-1:0] h_fp;
    logic [H_SIZE-1:0] h_sync;
    logic [H_SIZE-1:0] h_bp;
    logic [V_SIZE-1:0] v_active;
    logic [V_SIZE-1:0] v_fp;
    logic [V_SIZE-1:0] v_sync;
    logic [V_SIZE-1:0] v_bp;
    logic              hs_pol;
    logic              vs_pol;
  } cfg_t;

  localparam cfg_t DEF = '{H_SIZE'(H_ACTIVE), H_SIZE'(H_FP), H_SIZE'(H_SYNC), H_SIZE'(H_BP),
                           V_SIZE'(V_ACTIVE), V_SIZE'(V_FP), V_SIZE'(V_SYNC), V_SIZE'(V_BP),
                           1'(HS_POL), 1'(VS_POL)};
  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [H_SIZE+1:0] H_ONE = 1;
  localparam logic [V_SIZE+1:0] V_ONE = 1;

  cfg_t act, pend, cfg_in;
  logic [3:0] div_cnt;
  logic [H_SIZE+1:0] h_ext, h_total, hs_start, hs_end;
  logic [V_SIZE+1:0] v_ext, v_total, vs_start, vs_end;
  logic h_last, v_last, apply;

  assign cfg_in = {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                   cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hs_pol, cfg_vs_pol};

  // Timing decode: totals and sync windows are widened by two bits so the sums never wrap
  always_comb begin
    h_ext       = {2'b0, hcount};
    v_ext       = {2'b0, vcount};
    h_total     = {2'b0, act.h_active} + {2'b0, act.h_fp} + {2'b0, act.h_sync} + {2'b0, act.h_bp};
    v_total     = {2'b0, act.v_active} + {2'b0, act.v_fp} + {2'b0, act.v_sync} + {2'b0, act.v_bp};
    hs_start    = {2'b0, act.h_active} + {2'b0, act.h_fp};
    vs_start    = {2'b0, act.v_active} + {2'b0, act.v_fp};
    hs_end      = hs_start + {2'b0, act.h_sync};
    vs_end      = vs_start + {2'b0, act.v_sync};
    h_last      = h_ext + H_ONE == h_total;
    v_last      = v_ext + V_ONE == v_total;
    pix_tick    = !rst && div_cnt == DIV_MAX;
    hsync       = rst ? ~DEF.hs_pol : (h_ext >= hs_start && h_ext < hs_end) ? act.hs_pol : ~act.hs_pol;
    vsync       = rst ? ~DEF.vs_pol : (v_ext >= vs_start && v_ext < vs_end) ? act.vs_pol : ~act.vs_pol;
    video_on    = hcount < act.h_active && vcount < act.v_active;
    line_start  = pix_tick && hcount == '0;
    frame_start = line_start && vcount == '0;
    frame_end   = pix_tick && h_last && v_last;
    apply       = clear ? (cfg_pending | cfg_update) : (frame_end & cfg_pending);
  end

  // Divider, counters and the active/pending config registers
  always_ff @(posedge clk) begin
    if (rst) begin
      act         <= DEF;
      pend        <= '0;
      cfg_pending <= 1'b0;
      cfg_done    <= 1'b0;
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
    end else begin
      cfg_done    <= apply;
      cfg_pending <= cfg_update ? !clear : cfg_pending & !apply;
      if (cfg_update) pend <= cfg_in;
      if (apply) act <= (clear & cfg_update) ? cfg_in : pend;
      div_cnt     <= (clear | pix_tick) ? '0 : div_cnt + 4'd1;
      hcount      <= clear ? '0 : pix_tick ? (h_last ? '0 : hcount + 1'b1) : hcount;
      vcount      <= clear ? '0 : (pix_tick & h_last) ? (v_last ? '0 : vcount + 1'b1) : vcount;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen at CLK_DIV 1 and 4 against a frame-level model
module tb_vga_timing_gen;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } mode_t;
  typedef struct packed {
    logic [29:0] e;
    logic [29:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst, clear, cfg_update;
  logic [10:0] c_ha, c_hf, c_hs, c_hb;
  logic [9:0] c_va, c_vf, c_vs, c_vb;
  logic c_hp, c_vp;
  logic [1:0][29:0] got;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mode_t dflt = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  mode_t act[2], pend[2];
  bit mpend[2], mdone[2], known[2];
  int dv[2], mh[2], mv[2];
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [10:0] hc;
    logic [9:0] vc;
    logic pt, ls, fs, fe, hs, vs, vo, pe, dn;
    vga_timing_gen #(.CLK_DIV(g == 0 ? 1 : 4)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .cfg_h_active(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
      .cfg_v_active(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
      .cfg_hs_pol(c_hp), .cfg_vs_pol(c_vp), .cfg_update(cfg_update),
      .cfg_pending(pe), .cfg_done(dn), .pix_tick(pt), .hcount(hc), .vcount(vc),
      .hsync(hs), .vsync(vs), .video_on(vo),
      .line_start(ls), .frame_start(fs), .frame_end(fe)
    );
    assign got[g] = {pt, ls, fs, fe, hs, vs, vo, pe, dn, hc, vc};
  end

  function automatic int div_of(int i);
    return i == 0 ? 1 : 4;
  endfunction

  function automatic int htot(int i);
    return act[i].ha + act[i].hf + act[i].hs + act[i].hb;
  endfunction

  function automatic int vtot(int i);
    return act[i].va + act[i].vf + act[i].vs + act[i].vb;
  endfunction

  function automatic bit fe_now(int i);
    return dv[i] == div_of(i) - 1 && mh[i] == htot(i) - 1 && mv[i] == vtot(i) - 1;
  endfunction

  function automatic exp_t expect_out(int i, bit r);
    exp_t x;
    bit tick, hin, vin, hsy, vsy;
    tick = !r && dv[i] == div_of(i) - 1;
    hin  = mh[i] >= act[i].ha + act[i].hf && mh[i] < act[i].ha + act[i].hf + act[i].hs;
    vin  = mv[i] >= act[i].va + act[i].vf && mv[i] < act[i].va + act[i].vf + act[i].vs;
    hsy  = r ? !dflt.hp : (hin ? act[i].hp : !act[i].hp);
    vsy  = r ? !dflt.vp : (vin ? act[i].vp : !act[i].vp);
    x.e  = {tick, tick && mh[i] == 0, tick && mh[i] == 0 && mv[i] == 0, tick && fe_now(i),
            hsy, vsy, mh[i] < act[i].ha && mv[i] < act[i].va, mpend[i], mdone[i],
            11'(mh[i]), 10'(mv[i])};
    x.m  = known[i] ? '1 : {6'h3f, 24'h0};
    return x;
  endfunction

  task automatic step(int i, bit r, bit c, bit up, mode_t m);
    int ht, vt;
    bit tick, fe;
    if (r) begin
      act[i] = dflt; pend[i] = dflt; mpend[i] = 0; mdone[i] = 0;
      dv[i] = 0; mh[i] = 0; mv[i] = 0; known[i] = 1;
      return;
    end
    ht = htot(i);
    vt = vtot(i);
    tick = dv[i] == div_of(i) - 1;
    fe = fe_now(i);
    mdone[i] = c ? (mpend[i] || up) : (fe && mpend[i]);
    if (c) begin
      if (up) act[i] = m;
      else if (mpend[i]) act[i] = pend[i];
      mpend[i] = 0;
    end else begin
      if (fe && mpend[i]) begin
        act[i] = pend[i];
        mpend[i] = 0;
      end
      if (up) mpend[i] = 1;
    end
    if (up) pend[i] = m;
    if (c) begin
      dv[i] = 0; mh[i] = 0; mv[i] = 0;
    end else begin
      if (tick) begin
        mh[i] = (mh[i] + 1) % ht;
        if (mh[i] == 0) mv[i] = (mv[i] + 1) % vt;
      end
      dv[i] = (dv[i] + 1) % div_of(i);
    end
  endtask

  task automatic drive(bit r, bit c, bit up, mode_t m);
    rst = r; clear = c; cfg_update = up;
    c_ha = 11'(m.ha); c_hf = 11'(m.hf); c_hs = 11'(m.hs); c_hb = 11'(m.hb);
    c_va = 10'(m.va); c_vf = 10'(m.vf); c_vs = 10'(m.vs); c_vb = 10'(m.vb);
    c_hp = m.hp; c_vp = m.vp;
    q0.push_back(expect_out(0, r));
    q1.push_back(expect_out(1, r));
    step(0, r, c, up, m);
    step(1, r, c, up, m);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    mode_t z = dflt;
    for (int k = 0; k < n; k++) drive(0, 0, 0, z);
  endtask

  function automatic mode_t rnd_mode();
    mode_t m;
    m.ha = $urandom_range(1, 24); m.hf = $urandom_range(0, 4);
    m.hs = $urandom_range(0, 5);  m.hb = $urandom_range(0, 4);
    m.va = $urandom_range(1, 8);  m.vf = $urandom_range(0, 2);
    m.vs = $urandom_range(0, 3);  m.vb = $urandom_range(0, 2);
    m.hp = 1'($urandom_range(0, 1)); m.vp = 1'($urandom_range(0, 1));
    return m;
  endfunction

  task automatic update_at_fe(mode_t m);
    int k = 0;
    while (!fe_now(0) && k < 6000) begin
      idle(1);
      k++;
    end
    checks++;
    if (!fe_now(0)) begin
      failures++;
      $display("FAIL fe_wait cycles=%0d required frame_end within 6000", k);
    end
    drive(0, 0, 1, m);
  endtask

  task automatic compare(string name, logic [29:0] g, exp_t x);
    checks++;
    if ((g & x.m) !== (x.e & x.m)) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h", name, cyc, g, x.e, x.m);
    end
  endtask

  // Scoreboard monitor: one expected record per DUT per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q0.size() > 0) compare("div1", got[0], q0.pop_front());
    if (q1.size() > 0) compare("div4", got[1], q1.pop_front());
  end

  initial begin
    mode_t ma, mt, m1, m2, m3;
    int r;
    ma = '{20, 3, 5, 4, 8, 2, 2, 3, 1'b0, 1'b1};
    mt = '{8, 2, 4, 2, 6, 1, 2, 1, 1'b1, 1'b1};
    known[0] = 0; known[1] = 0;
    act[0] = dflt; act[1] = dflt; pend[0] = dflt; pend[1] = dflt;
    rst = 1; clear = 0; cfg_update = 0;
    c_ha = '0; c_hf = '0; c_hs = '0; c_hb = '0; c_va = '0; c_vf = '0; c_vs = '0; c_vb = '0;
    c_hp = 0; c_vp = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) drive(1, 0, 0, dflt);
    idle(1800);
    drive(0, 1, 1, ma);
    idle(300);
    drive(0, 0, 1, mt);
    idle(2200);
    m1 = rnd_mode(); m2 = rnd_mode(); m3 = rnd_mode();
    drive(0, 0, 1, m1);
    idle(5);
    drive(0, 0, 1, m2);
    update_at_fe(m3);
    idle(3000);
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 400));
      r = $urandom_range(0, 9);
      if (r < 7) drive(0, 0, 1, rnd_mode());
      else if (r == 7) drive(0, 1, 0, dflt);
      else if (r == 8) drive(0, 1, 1, rnd_mode());
      else update_at_fe(rnd_mode());
    end
    drive(0, 0, 1, rnd_mode());
    idle(37);
    drive(0, 1, 0, dflt);
    idle(50);
    drive(0, 0, 1, rnd_mode());
    idle(10);
    drive(1, 1, 0, dflt);
    idle(1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
